// File: rtl/circ_idx_alloc.sv
// Circular-queue pointer allocator shared by the in-order backend buffers.
// Pointers are {flip, idx}; all outputs derive combinationally from head/tail.
module circ_idx_alloc #(
  parameter int SIZE        = 128,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  localparam int IW   = $clog2(SIZE),
  localparam int PTRW = IW + 1,
  localparam int CW   = $clog2(SIZE) + 1,
  localparam int FNW  = $clog2(FREE_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ALLOC_WIDTH-1:0]      i_alloc_req,
  output logic                        o_can_alloc,
  output logic [ALLOC_WIDTH*PTRW-1:0] o_alloc_idx,
  input  logic [FNW-1:0]              i_free_num,
  input  logic                        i_squash,
  input  logic [PTRW-1:0]             i_squash_idx,
  input  logic                        i_flush,
  output logic [PTRW-1:0]             o_head,
  output logic [PTRW-1:0]             o_tail,
  output logic [CW-1:0]               o_count,
  output logic                        o_empty,
  output logic                        o_full,
  output logic                        o_err
);

  logic [PTRW-1:0]      r_head;
  logic [PTRW-1:0]      r_tail;
  logic                 r_err;

  logic [PTRW-1:0]      w_count;
  logic [PTRW-1:0]      w_req_cnt;
  logic [ALLOC_WIDTH:0] w_req_p1;
  logic                 w_not_packed;
  logic                 w_free_ovf;
  logic [PTRW-1:0]      w_squash_dist;
  logic                 w_squash_bad;
  logic                 w_alloc_fire;
  logic                 w_can_alloc;

  assign w_count = r_tail - r_head;

  always_comb begin
    w_req_cnt = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      w_req_cnt = w_req_cnt + PTRW'(i_alloc_req[k]);
    end
  end

  // A low-packed mask is 0..01..1, so adding one leaves no common set bit.
  assign w_req_p1     = {1'b0, i_alloc_req} + (ALLOC_WIDTH+1)'(1);
  assign w_not_packed = |(i_alloc_req & w_req_p1[ALLOC_WIDTH-1:0]);

  assign w_free_ovf    = 32'(i_free_num) > 32'(w_count);
  assign w_squash_dist = i_squash_idx - r_head;
  assign w_squash_bad  = i_squash && (w_squash_dist > w_count);

  assign w_can_alloc  = (32'(w_count) + 32'(ALLOC_WIDTH)) <= 32'(SIZE);
  assign w_alloc_fire = w_can_alloc && (|i_alloc_req) && !i_squash && !i_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_err  <= 1'b0;
    end else begin
      if (i_flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        r_head <= r_head + PTRW'(i_free_num);
        if (i_squash) begin
          r_tail <= i_squash_idx;
        end else if (w_alloc_fire) begin
          r_tail <= r_tail + w_req_cnt;
        end
      end
      // State still updates on a violating cycle; only the flag records it.
      if (w_free_ovf || w_squash_bad || w_not_packed) begin
        r_err <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_lane
      assign o_alloc_idx[gi*PTRW +: PTRW] = r_tail + PTRW'(gi);
    end
  endgenerate

  assign o_can_alloc = w_can_alloc;
  assign o_head      = r_head;
  assign o_tail      = r_tail;
  assign o_count     = CW'(w_count);
  assign o_empty     = (r_head == r_tail);
  assign o_full      = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);
  assign o_err       = r_err;

endmodule

// File: tb/tb_circ_idx_alloc.sv
// Directed bench for circ_idx_alloc: three instances (SIZE 32, 8, 16) exercise
// fill-to-full, wrap, squash with free, error flag, flush and reset.
module tb_circ_idx_alloc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: SIZE=32, PTRW=6
  logic [3:0]  a_req = '0;
  logic        a_can;
  logic [23:0] a_idx;
  logic [2:0]  a_free = '0;
  logic        a_squash = 1'b0;
  logic [5:0]  a_sidx = '0;
  logic        a_flush = 1'b0;
  logic [5:0]  a_head, a_tail, a_count;
  logic        a_empty, a_full, a_err;

  // Instance B: SIZE=8, PTRW=4
  logic [3:0]  b_req = '0;
  logic        b_can;
  logic [15:0] b_idx;
  logic [2:0]  b_free = '0;
  logic        b_squash = 1'b0;
  logic [3:0]  b_sidx = '0;
  logic        b_flush = 1'b0;
  logic [3:0]  b_head, b_tail, b_count;
  logic        b_empty, b_full, b_err;

  // Instance C: SIZE=16, PTRW=5
  logic [3:0]  c_req = '0;
  logic        c_can;
  logic [19:0] c_idx;
  logic [2:0]  c_free = '0;
  logic        c_squash = 1'b0;
  logic [4:0]  c_sidx = '0;
  logic        c_flush = 1'b0;
  logic [4:0]  c_head, c_tail, c_count;
  logic        c_empty, c_full, c_err;

  circ_idx_alloc #(.SIZE(32), .ALLOC_WIDTH(4), .FREE_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .i_alloc_req(a_req), .o_can_alloc(a_can),
    .o_alloc_idx(a_idx), .i_free_num(a_free), .i_squash(a_squash),
    .i_squash_idx(a_sidx), .i_flush(a_flush), .o_head(a_head), .o_tail(a_tail),
    .o_count(a_count), .o_empty(a_empty), .o_full(a_full), .o_err(a_err));

  circ_idx_alloc #(.SIZE(8), .ALLOC_WIDTH(4), .FREE_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .i_alloc_req(b_req), .o_can_alloc(b_can),
    .o_alloc_idx(b_idx), .i_free_num(b_free), .i_squash(b_squash),
    .i_squash_idx(b_sidx), .i_flush(b_flush), .o_head(b_head), .o_tail(b_tail),
    .o_count(b_count), .o_empty(b_empty), .o_full(b_full), .o_err(b_err));

  circ_idx_alloc #(.SIZE(16), .ALLOC_WIDTH(4), .FREE_WIDTH(4)) u_c (
    .clk(clk), .rst(rst), .i_alloc_req(c_req), .o_can_alloc(c_can),
    .o_alloc_idx(c_idx), .i_free_num(c_free), .i_squash(c_squash),
    .i_squash_idx(c_sidx), .i_flush(c_flush), .o_head(c_head), .o_tail(c_tail),
    .o_count(c_count), .o_empty(c_empty), .o_full(c_full), .o_err(c_err));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    check_val("rst_head",  32'(a_head), 32'd0);
    check_val("rst_tail",  32'(a_tail), 32'd0);
    check_val("rst_count", 32'(a_count), 32'd0);
    check_val("rst_empty", 32'(a_empty), 32'd1);
    check_val("rst_full",  32'(a_full), 32'd0);
    check_val("rst_can",   32'(a_can), 32'd1);
    check_val("rst_err",   32'(a_err), 32'd0);
    check_val("rst_idx",   32'(a_idx), {8'h0, 6'd3, 6'd2, 6'd1, 6'd0});
    rst = 1'b0;

    // Wrap on SIZE=8: alloc 4 / free 4 alternating
    for (int r = 0; r < 3; r++) begin
      b_req = 4'hF;
      #1;
      if (r < 2) begin
        check_val($sformatf("wrap_lane0_%0d", r), 32'(b_idx[3:0]), 32'(4 * r));
      end else begin
        check_val("wrap_lanes_flip", 32'(b_idx), 32'hBA98);
      end
      tick();
      b_req = 4'h0;
      b_free = 3'd4;
      tick();
      b_free = 3'd0;
      check_val($sformatf("wrap_empty_%0d", r), 32'(b_empty), 32'd1);
    end
    check_val("wrap_tail", 32'(b_tail), 32'hC);
    check_val("wrap_err",  32'(b_err), 32'd0);

    // Build head=2, tail=10 on SIZE=16, then squash+free+alloc together
    c_req = 4'hF; tick(); tick();
    c_req = 4'b0011; tick();
    c_req = 4'h0; c_free = 3'd2; tick();
    c_free = 3'd0;
    check_val("sq_pre_head",  32'(c_head), 32'd2);
    check_val("sq_pre_tail",  32'(c_tail), 32'd10);
    check_val("sq_pre_count", 32'(c_count), 32'd8);
    c_squash = 1'b1; c_sidx = 5'd6; c_free = 3'd2; c_req = 4'b0011;
    tick();
    c_squash = 1'b0; c_free = 3'd0; c_req = 4'h0;
    check_val("sq_head",  32'(c_head), 32'd4);
    check_val("sq_tail",  32'(c_tail), 32'd6);
    check_val("sq_count", 32'(c_count), 32'd2);
    check_val("sq_err",   32'(c_err), 32'd0);
    c_req = 4'b0101; tick();
    c_req = 4'h0;
    check_val("unpacked_tail", 32'(c_tail), 32'd8);
    check_val("unpacked_err",  32'(c_err), 32'd1);

    // Fill SIZE=32 to full
    a_req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_val($sformatf("fill_lane0_%0d", k), 32'(a_idx[5:0]), 32'(4 * k));
      tick();
    end
    a_req = 4'h0;
    check_val("full_flag",  32'(a_full), 32'd1);
    check_val("full_count", 32'(a_count), 32'd32);
    check_val("full_can",   32'(a_can), 32'd0);
    a_req = 4'hF; tick();
    a_req = 4'h0;
    check_val("full_tail_hold", 32'(a_tail), 32'd32);

    // Flush while full with a pending alloc
    a_flush = 1'b1; a_req = 4'hF; tick();
    a_flush = 1'b0; a_req = 4'h0;
    check_val("flush_head",  32'(a_head), 32'd0);
    check_val("flush_tail",  32'(a_tail), 32'd0);
    check_val("flush_empty", 32'(a_empty), 32'd1);
    check_val("flush_can",   32'(a_can), 32'd1);

    // Free overflow: count=3, free 4
    a_req = 4'b0111; tick();
    a_req = 4'h0;
    check_val("ovf_count", 32'(a_count), 32'd3);
    check_val("ovf_err_pre", 32'(a_err), 32'd0);
    a_free = 3'd4; tick();
    a_free = 3'd0;
    check_val("ovf_err", 32'(a_err), 32'd1);
    tick(); tick();
    check_val("ovf_err_sticky", 32'(a_err), 32'd1);

    // Reset during squash
    rst = 1'b1; a_squash = 1'b1; a_sidx = 6'd2; a_req = 4'hF;
    tick();
    rst = 1'b0; a_squash = 1'b0; a_req = 4'h0;
    check_val("rst2_head",  32'(a_head), 32'd0);
    check_val("rst2_tail",  32'(a_tail), 32'd0);
    check_val("rst2_count", 32'(a_count), 32'd0);
    check_val("rst2_empty", 32'(a_empty), 32'd1);
    check_val("rst2_full",  32'(a_full), 32'd0);
    check_val("rst2_can",   32'(a_can), 32'd1);
    check_val("rst2_err",   32'(a_err), 32'd0);
    check_val("rst2_idx",   32'(a_idx), {8'h0, 6'd3, 6'd2, 6'd1, 6'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
